usb_rx_destuff: RTL and testbench

Receive-path stage between the line sampler and the CRC/packet logic of the full-speed SIE. It takes one sampled line symbol per strobe and performs NRZI decoding, SYNC detection, bit unstuffing and EOP detection. It emits a destuffed serial bit stream with a per-bit valid, which drives `usb_crc` `data`/`VALID` directly. It also assembles the stream into LSb-first bytes for the packet layer.

---
 rtl/usb_rx_pkg.sv | 22 ++
 rtl/usb_nrzi_decoder.sv | 43 ++++
 rtl/usb_rx_destuff.sv | 257 +++++++++++++++++++++++++
 tb/tb_usb_rx_destuff.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg -- shared types and constants for the full-speed receive path.
//
// Contents:
//   rx_state_t    receive FSM state (IDLE, SYNC, DATA, EOP, ERR)
//   STUFF_RUN     run of decoded ones after which the next bit is a stuff bit
//   J_LEVEL       sampled differential level that represents J (idle)
//   ZERO_CNT_MAX  saturation value of the SYNC zero counter
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    DATA = 3'd2,
    EOP  = 3'd3,
    ERR  = 3'd4
  } rx_state_t;

  localparam logic [2:0] STUFF_RUN    = 3'd6;
  localparam logic       J_LEVEL      = 1'b1;
  localparam logic [2:0] ZERO_CNT_MAX = 3'd7;

endpackage

// File: rtl/usb_nrzi_decoder.sv
// usb_nrzi_decoder -- NRZI decoder front end of the receive path.
//
// Holds the previous non-SE0 line level and decodes the current sample
// combinationally: an unchanged level is a 1, a transition is a 0.
//
// Ports:
//   clk12           in   12 MHz clock
//   RST             in   synchronous, active-high reset (level returns to J)
//   i_sample_valid  in   a new line sample is present this cycle
//   i_rx_bit        in   sampled differential level, 1 = J, 0 = K
//   i_rx_se0        in   both lines low on this sample
//   o_dec           out  decoded NRZI bit for the current sample
//   o_se0           out  current sample is SE0
//   o_is_j          out  current sample is a J level (not SE0)
module usb_nrzi_decoder
  import usb_rx_pkg::*;
(
  input  logic clk12,
  input  logic RST,
  input  logic i_sample_valid,
  input  logic i_rx_bit,
  input  logic i_rx_se0,
  output logic o_dec,
  output logic o_se0,
  output logic o_is_j
);

  logic r_prev_level;

  // SE0 carries no differential level, so it never updates the reference.
  always_ff @(posedge clk12) begin
    if (RST) begin
      r_prev_level <= J_LEVEL;
    end else if (i_sample_valid && !i_rx_se0) begin
      r_prev_level <= i_rx_bit;
    end
  end

  assign o_dec  = (i_rx_bit == r_prev_level);
  assign o_se0  = i_rx_se0;
  assign o_is_j = !i_rx_se0 && (i_rx_bit == J_LEVEL);

endmodule

// File: rtl/usb_rx_destuff.sv
// usb_rx_destuff -- full-speed receive stage: NRZI decode, SYNC detect,
// bit unstuffing, EOP detect and LSb-first byte assembly.
//
// Optional feature macro: USB_RX_STUFF_ERROR_EN
//   defined   : a 1 in a stuff-bit position pulses stuffErr and parks the FSM
//               in ERR until SE0 followed by J.
//   undefined : the stuff-bit position is dropped whatever its value, stuffErr
//               is tied low and no ERR logic exists.
//
// Input qualification: sampleValid is a pure strobe with no back-pressure.
// rxBit/rxSE0 are looked at only on cycles where sampleValid is high, and
// every registered output (including pulses) is recomputed only from such a
// sample; pulses fall back to 0 on the following cycle.
//
// Ports:
//   clk12        in   12 MHz clock
//   RST          in   synchronous, active-high reset
//   sampleValid  in   new line sample this cycle
//   rxBit        in   sampled differential level, 1 = J, 0 = K
//   rxSE0        in   both lines low on this sample
//   rxActive     out  packet in progress (SYNC accepted, not yet ended)
//   dataOut      out  destuffed decoded bit
//   dataValid    out  dataOut is a payload bit (one-cycle pulse)
//   rxByte       out  byte shift register, LSb received first
//   rxByteValid  out  rxByte holds a complete byte (one-cycle pulse)
//   eop          out  packet end (one-cycle pulse)
//   eopAligned   out  qualifies eop: ended on a byte boundary without error
//   stuffErr     out  bit-stuff violation (one-cycle pulse)
//   o_dbg_state  out  current FSM state, for observation only
module usb_rx_destuff
  import usb_rx_pkg::*;
#(
  parameter int SYNC_MIN_ZEROS = 5
)
(
  input  logic       clk12,
  input  logic       RST,
  input  logic       sampleValid,
  input  logic       rxBit,
  input  logic       rxSE0,
  output logic       rxActive,
  output logic       dataOut,
  output logic       dataValid,
  output logic [7:0] rxByte,
  output logic       rxByteValid,
  output logic       eop,
  output logic       eopAligned,
  output logic       stuffErr,
  output rx_state_t  o_dbg_state
);

  localparam logic [2:0] SYNC_MIN = 3'(SYNC_MIN_ZEROS);

  // Decoder outputs for the current sample
  logic w_dec;
  logic w_se0;
  logic w_is_j;

  usb_nrzi_decoder u_nrzi (
    .clk12          (clk12),
    .RST            (RST),
    .i_sample_valid (sampleValid),
    .i_rx_bit       (rxBit),
    .i_rx_se0       (rxSE0),
    .o_dec          (w_dec),
    .o_se0          (w_se0),
    .o_is_j         (w_is_j)
  );

  // State and output registers
  rx_state_t  r_state;
  logic [2:0] r_zero_cnt;
  logic [2:0] r_ones_cnt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_byte;
  logic       r_data_out;
  logic       r_data_valid;
  logic       r_byte_valid;
  logic       r_eop;
  logic       r_eop_aligned;
  logic       r_rx_active;

  // Next-state values
  rx_state_t  w_state;
  logic [2:0] w_zero_cnt;
  logic [2:0] w_ones_cnt;
  logic [2:0] w_bit_cnt;
  logic [7:0] w_byte;
  logic       w_data_out;
  logic       w_data_valid;
  logic       w_byte_valid;
  logic       w_eop;
  logic       w_eop_aligned;
  logic       w_rx_active;

`ifdef USB_RX_STUFF_ERROR_EN
  // r_err_se0 remembers that an SE0 has been seen while in ERR, so the next
  // J closes the errored packet.
  logic r_stuff_err;
  logic r_err_se0;
  logic w_stuff_err;
  logic w_err_se0;
`endif

  always_ff @(posedge clk12) begin
    if (RST) begin
      r_state       <= IDLE;
      r_zero_cnt    <= '0;
      r_ones_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_byte        <= 8'h00;
      r_data_out    <= 1'b0;
      r_data_valid  <= 1'b0;
      r_byte_valid  <= 1'b0;
      r_eop         <= 1'b0;
      r_eop_aligned <= 1'b0;
      r_rx_active   <= 1'b0;
`ifdef USB_RX_STUFF_ERROR_EN
      r_stuff_err   <= 1'b0;
      r_err_se0     <= 1'b0;
`endif
    end else begin
      r_state       <= w_state;
      r_zero_cnt    <= w_zero_cnt;
      r_ones_cnt    <= w_ones_cnt;
      r_bit_cnt     <= w_bit_cnt;
      r_byte        <= w_byte;
      r_data_out    <= w_data_out;
      r_data_valid  <= w_data_valid;
      r_byte_valid  <= w_byte_valid;
      r_eop         <= w_eop;
      r_eop_aligned <= w_eop_aligned;
      r_rx_active   <= w_rx_active;
`ifdef USB_RX_STUFF_ERROR_EN
      r_stuff_err   <= w_stuff_err;
      r_err_se0     <= w_err_se0;
`endif
    end
  end

  always_comb begin
    w_state       = r_state;
    w_zero_cnt    = r_zero_cnt;
    w_ones_cnt    = r_ones_cnt;
    w_bit_cnt     = r_bit_cnt;
    w_byte        = r_byte;
    w_data_out    = r_data_out;
    w_data_valid  = 1'b0;
    w_byte_valid  = 1'b0;
    w_eop         = 1'b0;
    w_eop_aligned = 1'b0;
    w_rx_active   = r_rx_active;
`ifdef USB_RX_STUFF_ERROR_EN
    w_stuff_err   = 1'b0;
    w_err_se0     = r_err_se0;
`endif

    if (sampleValid) begin
      case (r_state)
        IDLE: begin
          // SE0 while idle is line noise and is ignored.
          if (!w_se0 && !w_dec) begin
            w_state    = SYNC;
            w_zero_cnt = 3'd1;
          end
        end

        SYNC: begin
          if (w_se0) begin
            w_state = IDLE;
          end else if (!w_dec) begin
            if (r_zero_cnt != ZERO_CNT_MAX) begin
              w_zero_cnt = r_zero_cnt + 3'd1;
            end
          end else if (r_zero_cnt >= SYNC_MIN) begin
            // The SYNC-final 1 already starts the stuffing run.
            w_state     = DATA;
            w_rx_active = 1'b1;
            w_ones_cnt  = 3'd1;
            w_bit_cnt   = 3'd0;
          end else begin
            w_state = IDLE;
          end
        end

        DATA: begin
          if (w_se0) begin
            w_state = EOP;
          end else if (r_ones_cnt == STUFF_RUN) begin
            // Stuff-bit position: never a payload bit.
            w_ones_cnt = 3'd0;
`ifdef USB_RX_STUFF_ERROR_EN
            if (w_dec) begin
              w_stuff_err = 1'b1;
              w_err_se0   = 1'b0;
              w_state     = ERR;
            end
`endif
          end else begin
            w_data_valid = 1'b1;
            w_data_out   = w_dec;
            w_ones_cnt   = w_dec ? (r_ones_cnt + 3'd1) : 3'd0;
            w_byte       = {w_dec, r_byte[7:1]};
            w_bit_cnt    = r_bit_cnt + 3'd1;
            w_byte_valid = (r_bit_cnt == 3'd7);
          end
        end

        EOP: begin
          if (!w_se0) begin
            w_eop         = 1'b1;
            w_eop_aligned = w_is_j && (r_bit_cnt == 3'd0);
            w_rx_active   = 1'b0;
            w_state       = IDLE;
          end
        end

`ifdef USB_RX_STUFF_ERROR_EN
        ERR: begin
          if (w_se0) begin
            w_err_se0 = 1'b1;
          end else if (r_err_se0 && w_is_j) begin
            w_eop       = 1'b1;
            w_rx_active = 1'b0;
            w_err_se0   = 1'b0;
            w_state     = IDLE;
          end else begin
            // A K after the SE0 is not an end of packet; keep waiting.
            w_err_se0 = 1'b0;
          end
        end
`endif

        default: begin
          w_state     = IDLE;
          w_rx_active = 1'b0;
        end
      endcase
    end
  end

  assign rxActive    = r_rx_active;
  assign dataOut     = r_data_out;
  assign dataValid   = r_data_valid;
  assign rxByte      = r_byte;
  assign rxByteValid = r_byte_valid;
  assign eop         = r_eop;
  assign eopAligned  = r_eop_aligned;
  assign o_dbg_state = r_state;

`ifdef USB_RX_STUFF_ERROR_EN
  assign stuffErr = r_stuff_err;
`else
  assign stuffErr = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx_destuff.sv
// tb_usb_rx_destuff -- bench for usb_rx_destuff.
//
// Payload bit lists are bit-stuffed and NRZI-encoded onto the line by a
// behavioural encoder, framed by SYNC and SE0 SE0 J. The monitor records
// every dataValid bit, rxByteValid byte, eop and stuffErr; after each packet
// the recorded streams are compared with the payload-derived expectations.
module tb_usb_rx_destuff;
  import usb_rx_pkg::*;

  localparam int SYNC_MIN = 5;
`ifdef USB_RX_STUFF_ERROR_EN
  localparam bit STUFF_ERR_ON = 1'b1;
`else
  localparam bit STUFF_ERR_ON = 1'b0;
`endif

  // Clock / reset
  logic clk12 = 1'b0;
  logic RST = 1'b1;
  always #5 clk12 = ~clk12;

  logic       sampleValid = 1'b0;
  logic       rxBit = 1'b1;
  logic       rxSE0 = 1'b0;
  logic       rxActive;
  logic       dataOut;
  logic       dataValid;
  logic [7:0] rxByte;
  logic       rxByteValid;
  logic       eop;
  logic       eopAligned;
  logic       stuffErr;
  rx_state_t  dbg_state;

  usb_rx_destuff #(.SYNC_MIN_ZEROS(SYNC_MIN)) dut (
    .clk12       (clk12),
    .RST         (RST),
    .sampleValid (sampleValid),
    .rxBit       (rxBit),
    .rxSE0       (rxSE0),
    .rxActive    (rxActive),
    .dataOut     (dataOut),
    .dataValid   (dataValid),
    .rxByte      (rxByte),
    .rxByteValid (rxByteValid),
    .eop         (eop),
    .eopAligned  (eopAligned),
    .stuffErr    (stuffErr),
    .o_dbg_state (dbg_state)
  );

  // Scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  logic [0:0] exp_bit_q[$];
  logic [7:0] exp_byte_q[$];
  logic [0:0] got_bit_q[$];
  logic [7:0] got_byte_q[$];
  logic [0:0] got_eop_q[$];
  int         got_errs;
  bit         active_seen;

  bit pay_q[$];
  bit cur_level = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge.
  always @(negedge clk12) begin
    if (dataValid)   got_bit_q.push_back(dataOut);
    if (rxByteValid) got_byte_q.push_back(rxByte);
    if (eop)         got_eop_q.push_back(eopAligned);
    if (stuffErr)    got_errs++;
    if (rxActive)    active_seen = 1'b1;
  end

  // Driver tasks
  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk12); #1;
      sampleValid = 1'b0;
      RST = 1'b0;
    end
  endtask

  // One line sample, preceded by 0..2 cycles without sampleValid.
  task automatic drive_sym(input bit se0, input bit lvl, input bit rst);
    idle_cycles($urandom_range(0, 2));
    @(posedge clk12); #1;
    sampleValid = 1'b1;
    rxSE0 = se0;
    rxBit = se0 ? 1'b0 : lvl;
    RST = rst;
  endtask

  // NRZI: a 0 toggles the line, a 1 keeps it.
  task automatic send_bit(input bit b);
    if (!b) cur_level = ~cur_level;
    drive_sym(1'b0, cur_level, 1'b0);
  endtask

  task automatic load_bits(input logic [31:0] v, input int n);
    logic [31:0] t;
    t = v;
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(t[i]);
  endtask

  task automatic load_random(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back($urandom_range(0, 3) != 0);
  endtask

  // Sends idle Js, a SYNC of sync_zeros zeros plus a 1, the payload in pay_q
  // (stuffed), and SE0 SE0 J. bad: replace the first stuff 0 with a 1.
  // rst_at >= 0: assert RST on the sample of that payload bit.
  task automatic run_packet(input string name, input int idle_js, input int sync_zeros,
                            input bit bad, input int rst_at);
    int   n;
    int   n_ok;
    int   run;
    int   nb;
    bit   accepted;
    bit   err_hit;
    bit   err_expected;
    bit   rst_hit;
    bit   exp_aligned;
    logic [7:0] b8;

    n = pay_q.size();
    accepted = (sync_zeros >= SYNC_MIN);
    got_bit_q.delete();
    got_byte_q.delete();
    got_eop_q.delete();
    exp_bit_q.delete();
    exp_byte_q.delete();
    got_errs = 0;
    active_seen = 1'b0;

    for (int k = 0; k < idle_js; k++) begin
      cur_level = 1'b1;
      drive_sym(1'b0, 1'b1, 1'b0);
    end
    for (int z = 0; z < sync_zeros; z++) send_bit(1'b0);
    send_bit(1'b1);

    n_ok = accepted ? n : 0;
    err_hit = 1'b0;
    err_expected = 1'b0;
    rst_hit = 1'b0;
    if (accepted) begin
      run = 1;
      for (int i = 0; i < n; i++) begin
        if (i == rst_at) begin
          drive_sym(1'b0, cur_level, 1'b1);
          @(posedge clk12); #1;
          sampleValid = 1'b0;
          RST = 1'b0;
          @(negedge clk12);
          check({name, "_rst_rxActive"}, 32'(rxActive), 32'd0);
          check({name, "_rst_dataValid"}, 32'(dataValid), 32'd0);
          check({name, "_rst_rxByte"}, 32'(rxByte), 32'd0);
          check({name, "_rst_state"}, 32'(dbg_state), 32'(IDLE));
          cur_level = 1'b1;
          rst_hit = 1'b1;
          n_ok = i;
          break;
        end
        send_bit(pay_q[i]);
        run = pay_q[i] ? run + 1 : 0;
        if (run == 6) begin
          if (bad && !err_hit) begin
            err_hit = 1'b1;
            if (STUFF_ERR_ON) begin
              err_expected = 1'b1;
              n_ok = i + 1;
            end
            send_bit(1'b1);
          end else begin
            send_bit(1'b0);
          end
          run = 0;
        end
      end
    end

    if (!rst_hit) begin
      drive_sym(1'b1, 1'b0, 1'b0);
      drive_sym(1'b1, 1'b0, 1'b0);
      cur_level = 1'b1;
      drive_sym(1'b0, 1'b1, 1'b0);
    end
    idle_cycles(3);

    // Expected streams derived from the payload
    for (int i = 0; i < n_ok; i++) exp_bit_q.push_back(pay_q[i]);
    nb = n_ok / 8;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 8; j++) b8[j] = pay_q[k * 8 + j];
      exp_byte_q.push_back(b8);
    end
    exp_aligned = !err_expected && ((n_ok % 8) == 0);

    check({name, "_nbits"}, 32'(got_bit_q.size()), 32'(exp_bit_q.size()));
    for (int i = 0; i < exp_bit_q.size() && i < got_bit_q.size(); i++)
      check({name, "_bit"}, 32'(got_bit_q[i]), 32'(exp_bit_q[i]));
    check({name, "_nbytes"}, 32'(got_byte_q.size()), 32'(exp_byte_q.size()));
    for (int k = 0; k < exp_byte_q.size() && k < got_byte_q.size(); k++)
      check({name, "_byte"}, 32'(got_byte_q[k]), 32'(exp_byte_q[k]));
    check({name, "_neop"}, 32'(got_eop_q.size()), (accepted && !rst_hit) ? 32'd1 : 32'd0);
    if (got_eop_q.size() == 1 && accepted && !rst_hit)
      check({name, "_eop_aligned"}, 32'(got_eop_q[0]), 32'(exp_aligned));
    check({name, "_stuff_err"}, 32'(got_errs), 32'(err_expected));
    check({name, "_active_seen"}, 32'(active_seen), 32'(accepted));
    check({name, "_active_end"}, 32'(rxActive), 32'd0);
  endtask

  int rn;

  initial begin
    // Reset state
    RST = 1'b1;
    repeat (3) @(posedge clk12);
    @(negedge clk12);
    check("reset_rxActive", 32'(rxActive), 32'd0);
    check("reset_dataValid", 32'(dataValid), 32'd0);
    check("reset_rxByte", 32'(rxByte), 32'd0);
    check("reset_rxByteValid", 32'(rxByteValid), 32'd0);
    check("reset_eop", 32'(eop), 32'd0);
    check("reset_stuffErr", 32'(stuffErr), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk12); #1;
    RST = 1'b0;

    // Byte 0xC3 with full SYNC
    load_bits(32'hC3, 8);
    run_packet("c3", 3, 7, 1'b0, -1);

    // Byte 0x7F: stuff 0 after the fifth payload one
    load_bits(32'h7F, 8);
    run_packet("x7f", 3, 7, 1'b0, -1);

    // Stuff position carries a 1: bits 1,1,1,1,1 | bad 1 | 0,1,0
    load_bits(32'h5F, 8);
    run_packet("stuff_bad", 3, 7, 1'b1, -1);

    // Short SYNCs are rejected; minimum SYNC accepted
    load_random(8);
    run_packet("sync3", 3, 3, 1'b0, -1);
    load_random(8);
    run_packet("sync4", 3, SYNC_MIN - 1, 1'b0, -1);
    load_random(8);
    run_packet("sync5", 3, SYNC_MIN, 1'b0, -1);

    // 12-bit payload: one byte, unaligned end
    load_random(12);
    run_packet("bits12", 3, 7, 1'b0, -1);

    // Reset during the fourth payload bit, then a full packet
    load_random(10);
    run_packet("rst_mid", 3, 7, 1'b0, 3);
    load_bits(32'hA5, 8);
    run_packet("after_rst", 3, 7, 1'b0, -1);

    // SYNC directly after the EOP J
    load_bits(32'h3C, 8);
    run_packet("b2b", 0, 7, 1'b0, -1);

    // Empty payload
    pay_q.delete();
    run_packet("empty", 3, 7, 1'b0, -1);

    // Randomized packets
    for (int p = 0; p < 30; p++) begin
      rn = $urandom_range(0, 24);
      load_random(rn);
      run_packet("rand", $urandom_range(0, 3), $urandom_range(SYNC_MIN, 7),
                 $urandom_range(0, 3) == 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
